// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU functions,
// write-back selects, the FSM state enum and the registered control bundle.
package multicycle_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ITYPE = 6'd1;
    localparam logic [5:0] OP_LW    = 6'd2;
    localparam logic [5:0] OP_SW    = 6'd3;
    localparam logic [5:0] OP_BR    = 6'd4;
    localparam logic [5:0] OP_J     = 6'd5;
    localparam logic [5:0] OP_JR    = 6'd6;
    localparam logic [5:0] OP_JAL   = 6'd7;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;

    localparam logic [1:0] REG_RD   = 2'd0;
    localparam logic [1:0] REG_RT   = 2'd1;
    localparam logic [1:0] REG_LINK = 2'd2;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        ERROR
    } state_t;

    typedef struct packed {
        logic [1:0] reg_select;
        logic       writes;
        logic       mem_r;
        logic       mem_w;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic       comp_sel;
        logic       branch;
        logic       jump_to_reg;
        logic       label;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_instr_decoder.sv
// Combinational opcode/funct decode into the control bundle and ALU function;
// flags any opcode outside the supported set as illegal.
module instr_decoder
    import multicycle_control_fsm_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output ctrl_t              ctrl,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal
);

    // funct[5] carries no meaning for any supported class.
    logic funct_unused;
    assign funct_unused = funct[5];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        ctrl    = '0;
        alu_op  = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_op          = ALUOP_W'(funct[4:0]);
                ctrl.reg_select = REG_RD;
                ctrl.mem_to_reg = MTR_ALU;
                ctrl.writes     = 1'b1;
            end
            OP_ITYPE: begin
                alu_op          = ALUOP_W'(funct[4:0]);
                ctrl.alu_src    = 1'b1;
                ctrl.reg_select = REG_RT;
                ctrl.mem_to_reg = MTR_ALU;
                ctrl.writes     = 1'b1;
            end
            OP_LW: begin
                alu_op          = ALUOP_W'(ALU_ADD);
                ctrl.alu_src    = 1'b1;
                ctrl.mem_r      = 1'b1;
                ctrl.mem_to_reg = MTR_MEM;
                ctrl.reg_select = REG_RT;
                ctrl.writes     = 1'b1;
            end
            OP_SW: begin
                alu_op       = ALUOP_W'(ALU_ADD);
                ctrl.alu_src = 1'b1;
                ctrl.mem_w   = 1'b1;
            end
            OP_BR: begin
                alu_op        = ALUOP_W'(ALU_SUB);
                ctrl.branch   = 1'b1;
                ctrl.comp_sel = funct[0];
            end
            OP_J:  ctrl.label       = 1'b1;
            OP_JR: ctrl.jump_to_reg = 1'b1;
            OP_JAL: begin
                ctrl.label      = 1'b1;
                ctrl.reg_select = REG_LINK;
                ctrl.mem_to_reg = MTR_PC4;
                ctrl.writes     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with req/ack
// memory handshakes, bounded waits, sticky bus error and a retire counter.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int ALUOP_W = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               dmem_req,
    input  logic               dmem_ack,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         reg_select,
    output logic               reg_w,
    output logic               mem_r,
    output logic               mem_w,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               comp_sel,
    output logic               branch,
    output logic               jump_to_reg,
    output logic               label,
    output logic               illegal,
    output logic               bus_err,
    output logic [CNT_W-1:0]   retired
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    ctrl_t              ctrl_q;
    logic [ALUOP_W-1:0] alu_op_q;
    ctrl_t              dec_ctrl;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_illegal;
    logic               run;

    instr_decoder #(.ALUOP_W(ALUOP_W)) u_decoder (
        .opcode  (opcode),
        .funct   (funct),
        .ctrl    (dec_ctrl),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (imem_ack)                   state_next = DECODE;
                else if (wait_cnt == WAIT_LAST) state_next = ERROR;
            end
            DECODE:  state_next = dec_illegal ? FETCH : EXEC;
            EXEC:    state_next = (ctrl_q.mem_r || ctrl_q.mem_w) ? MEM : WB;
            MEM: begin
                // An ack on the final allowed cycle wins over the timeout.
                if (dmem_ack)                   state_next = WB;
                else if (wait_cnt == WAIT_LAST) state_next = ERROR;
            end
            WB:      state_next = FETCH;
            ERROR:   state_next = ERROR;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            // NOTE: the bundle register is reset because it drives outputs
            // directly and must read 0 straight out of reset.
            ctrl_q   <= '0;
            alu_op_q <= '0;
            bus_err  <= 1'b0;
            retired  <= '0;
        end else begin
            state <= state_next;

            if (state_next != state)
                wait_cnt <= '0;
            else if (state == FETCH || state == MEM)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (state == DECODE) begin
                ctrl_q   <= dec_ctrl;
                alu_op_q <= dec_alu_op;
            end

            if (state_next == ERROR && state != ERROR) begin
                bus_err  <= 1'b1;
                ctrl_q   <= '0;
                alu_op_q <= '0;
            end

            if (state == WB)
                retired <= retired + CNT_W'(1);
        end
    end

    // Strobes are masked while reset is held so the aborted access drops at once.
    assign run = ~rst;

    assign imem_req = run & (state == FETCH);
    assign ir_we    = run & (state == FETCH) & imem_ack;
    assign dmem_req = run & (state == MEM);
    assign mem_r    = run & (state == MEM) & ctrl_q.mem_r;
    assign mem_w    = run & (state == MEM) & ctrl_q.mem_w;
    assign reg_w    = run & (state == WB) & ctrl_q.writes;
    assign illegal  = run & (state == DECODE) & dec_illegal;
    assign pc_we    = run & ((state == WB) | ((state == DECODE) & dec_illegal));

    assign reg_select  = ctrl_q.reg_select;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign alu_src     = ctrl_q.alu_src;
    assign comp_sel    = ctrl_q.comp_sel;
    assign branch      = ctrl_q.branch;
    assign jump_to_reg = ctrl_q.jump_to_reg;
    assign label       = ctrl_q.label;
    assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: expected per-cycle strobes,
// control bundles and retire counts are queued at stimulus time and popped.
module tb_multicycle_control_fsm;

    localparam int ALUOP_W = 5;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [5:0]         opcode = '0;
    logic [5:0]         funct = '0;
    logic               imem_ack = 1'b0;
    logic               dmem_ack = 1'b0;
    logic               imem_req, dmem_req, ir_we, pc_we, reg_w, mem_r, mem_w;
    logic               alu_src, comp_sel, branch, jump_to_reg, label, illegal, bus_err;
    logic [1:0]         reg_select, mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic [CNT_W-1:0]   retired;

    multicycle_control_fsm #(.ALUOP_W(ALUOP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ir_we(ir_we), .pc_we(pc_we), .reg_select(reg_select), .reg_w(reg_w),
        .mem_r(mem_r), .mem_w(mem_w), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .alu_op(alu_op), .comp_sel(comp_sel), .branch(branch), .jump_to_reg(jump_to_reg),
        .label(label), .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic imem_req, ir_we, dmem_req, mem_r, mem_w, reg_w, pc_we, illegal, bus_err;
    } obs_t;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [1:0] reg_select;
        logic [1:0] mem_to_reg;
        logic       alu_src, comp_sel, branch, jump_to_reg, label;
    } bundle_t;

    typedef struct packed {
        obs_t o;
        logic imem_ack;
        logic dmem_ack;
        logic chk_bundle;
    } step_t;

    step_t            exp_q[$];
    bundle_t          bundle_q[$];
    logic [CNT_W-1:0] ret_q[$];
    logic [CNT_W-1:0] exp_retired = '0;
    logic             exp_bus_err = 1'b0;
    int               n_checks = 0;
    int               n_pass = 0;

    function automatic obs_t sample_obs();
        return {imem_req, ir_we, dmem_req, mem_r, mem_w, reg_w, pc_we, illegal, bus_err};
    endfunction

    function automatic bundle_t sample_bundle();
        return {alu_op, reg_select, mem_to_reg, alu_src, comp_sel, branch, jump_to_reg, label};
    endfunction

    function automatic bundle_t model_bundle(input logic [5:0] op, input logic [5:0] fn);
        bundle_t b;
        b = '0;
        case (op)
            6'd0: b.alu_op = fn[4:0];
            6'd1: begin b.alu_op = fn[4:0]; b.alu_src = 1'b1; b.reg_select = 2'd1; end
            6'd2: begin b.alu_src = 1'b1; b.mem_to_reg = 2'd1; b.reg_select = 2'd1; end
            6'd3: b.alu_src = 1'b1;
            6'd4: begin b.alu_op = 5'd1; b.branch = 1'b1; b.comp_sel = fn[0]; end
            6'd5: b.label = 1'b1;
            6'd6: b.jump_to_reg = 1'b1;
            6'd7: begin b.label = 1'b1; b.reg_select = 2'd2; b.mem_to_reg = 2'd2; end
            default: b = '0;
        endcase
        return b;
    endfunction

    // Queue the expected cycle-by-cycle behaviour of one instruction.
    // mw < 0 means the data memory never acknowledges.
    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        step_t st;
        logic  legal, wr, is_lw, is_sw;
        legal = (op <= 6'd7);
        wr    = (op == 6'd0) || (op == 6'd1) || (op == 6'd2) || (op == 6'd7);
        is_lw = (op == 6'd2);
        is_sw = (op == 6'd3);
        opcode = op;
        funct  = fn;
        for (int i = 0; i <= fw; i++) begin
            st = '0;
            st.o.imem_req = 1'b1;
            st.o.ir_we    = (i == fw);
            st.imem_ack   = (i == fw);
            st.o.bus_err  = exp_bus_err;
            exp_q.push_back(st);
        end
        st = '0;
        st.o.illegal = !legal;
        st.o.pc_we   = !legal;
        st.o.bus_err = exp_bus_err;
        exp_q.push_back(st);
        if (!legal) begin
            ret_q.push_back(exp_retired);
            return;
        end
        st = '0;
        st.o.bus_err = exp_bus_err;
        exp_q.push_back(st);
        if (is_lw || is_sw) begin
            if (mw < 0) begin
                for (int i = 0; i < TIMEOUT; i++) begin
                    st = '0;
                    st.o.dmem_req = 1'b1;
                    st.o.mem_r    = is_lw;
                    st.o.mem_w    = is_sw;
                    exp_q.push_back(st);
                end
                exp_bus_err = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    st = '0;
                    st.o.bus_err = 1'b1;
                    exp_q.push_back(st);
                end
                ret_q.push_back(exp_retired);
                return;
            end
            for (int i = 0; i <= mw; i++) begin
                st = '0;
                st.o.dmem_req = 1'b1;
                st.o.mem_r    = is_lw;
                st.o.mem_w    = is_sw;
                st.o.bus_err  = exp_bus_err;
                st.dmem_ack   = (i == mw);
                exp_q.push_back(st);
            end
        end
        st = '0;
        st.o.reg_w     = wr;
        st.o.pc_we     = 1'b1;
        st.o.bus_err   = exp_bus_err;
        st.chk_bundle  = 1'b1;
        exp_q.push_back(st);
        bundle_q.push_back(model_bundle(op, fn));
        exp_retired = exp_retired + 1'b1;
        ret_q.push_back(exp_retired);
    endtask

    // Consume queued steps; called and returns just after a rising edge.
    task automatic run_queue(input string name, input int max_steps);
        step_t   st;
        obs_t    got;
        bundle_t b_exp, b_got;
        int      cyc;
        cyc = 0;
        while (exp_q.size() != 0 && (max_steps < 0 || cyc < max_steps)) begin
            st = exp_q.pop_front();
            imem_ack = st.imem_ack;
            dmem_ack = st.dmem_ack;
            @(negedge clk);
            got = sample_obs();
            n_checks++;
            if (got !== st.o)
                $display("FAIL %s cycle %0d strobes: got %b expected %b", name, cyc, got, st.o);
            else
                n_pass++;
            if (st.chk_bundle) begin
                b_exp = bundle_q.pop_front();
                b_got = sample_bundle();
                n_checks++;
                if (b_got !== b_exp)
                    $display("FAIL %s bundle: got %h expected %h", name, b_got, b_exp);
                else
                    n_pass++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw);
        logic [CNT_W-1:0] r_exp;
        plan_instr(op, fn, fw, mw);
        run_queue(name, -1);
        r_exp = ret_q.pop_front();
        n_checks++;
        if (retired !== r_exp)
            $display("FAIL %s retired: got %0d expected %0d", name, retired, r_exp);
        else
            n_pass++;
    endtask

    // Hold reset for two edges, check the idle outputs, then release.
    task automatic test_reset(input string name);
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_retired = '0;
        exp_bus_err = 1'b0;
        n_checks++;
        if (sample_obs() !== obs_t'(0)) $display("FAIL %s strobes: got %b expected 0", name, sample_obs());
        else n_pass++;
        n_checks++;
        if (sample_bundle() !== bundle_t'(0)) $display("FAIL %s bundle: got %h expected 0", name, sample_bundle());
        else n_pass++;
        n_checks++;
        if (retired !== '0) $display("FAIL %s retired: got %0d expected 0", name, retired);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr("rtype_f03", 6'd0, 6'h03, 0, 0);
        run_instr("itype_slow_fetch", 6'd1, 6'h25, 2, 0);
    endtask

    task automatic test_lw();
        run_instr("lw_wait3", 6'd2, 6'h00, 0, 3);
    endtask

    task automatic test_illegal();
        run_instr("illegal_3f", 6'h3F, 6'h00, 0, 0);
        run_instr("br_after_illegal", 6'd4, 6'h01, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_instr("j", 6'd5, 6'h00, 0, 0);
        run_instr("jr", 6'd6, 6'h00, 1, 0);
        run_instr("jal", 6'd7, 6'h00, 0, 0);
        run_instr("sw_ack_at_limit", 6'd3, 6'h00, 0, TIMEOUT - 1);
    endtask

    task automatic test_reset_mid_mem();
        obs_t got;
        plan_instr(6'd2, 6'h00, 0, 10);
        run_queue("lw_before_reset", 6);
        exp_q.delete();
        bundle_q.delete();
        ret_q.delete();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        got = sample_obs();
        n_checks++;
        if (got !== obs_t'(0)) $display("FAIL reset_mid_mem strobes: got %b expected 0", got);
        else n_pass++;
        n_checks++;
        if (sample_bundle() !== bundle_t'(0)) $display("FAIL reset_mid_mem bundle: got %h expected 0", sample_bundle());
        else n_pass++;
        n_checks++;
        if (retired !== '0) $display("FAIL reset_mid_mem retired: got %0d expected 0", retired);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_retired = '0;
        exp_bus_err = 1'b0;
        run_instr("rtype_after_reset", 6'd0, 6'h11, 0, 0);
    endtask

    task automatic test_timeout();
        run_instr("sw_timeout", 6'd3, 6'h00, 0, -1);
        @(negedge clk);
        n_checks++;
        if (sample_bundle() !== bundle_t'(0)) $display("FAIL error_bundle: got %h expected 0", sample_bundle());
        else n_pass++;
        n_checks++;
        if (bus_err !== 1'b1) $display("FAIL error_sticky bus_err: got %b expected 1", bus_err);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        logic [5:0] op;
        logic [5:0] fn;
        test_reset("reset_before_wrap");
        n_checks++;
        if (bus_err !== 1'b0) $display("FAIL reset_clears_bus_err: got %b expected 0", bus_err);
        else n_pass++;
        for (int i = 0; i < 17; i++) begin
            op = 6'(i % 8);
            fn = 6'($urandom_range(0, 63));
            run_instr("wrap_seq", op, fn, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        n_checks++;
        if (retired !== 4'd1) $display("FAIL wrap_final retired: got %0d expected 1", retired);
        else n_pass++;
    endtask

    initial begin
        test_reset("reset");
        test_rtype();
        test_lw();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mem();
        test_timeout();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
